// File: rtl/collram_gen.sv
// Multi-port collision flag array with sticky summary, saturating event counter
// and a chunked sweep engine that clears the whole array in DEPTH/SWEEP_W cycles.
module collram_gen #(
    parameter int          ADDR_W  = 6,
    parameter int          N_SRC   = 1,
    parameter int          SWEEP_W = 16,
    parameter logic [5:0]  FILL    = 6'b111111
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic [ADDR_W-1:0]         cpu_ad,
    input  logic                      cpu_wr_coll,
    input  logic                      cpu_wr_collclr,
    input  logic                      cpu_wr_sweep,
    output logic [7:0]                cpu_rd_coll,
    input  logic [N_SRC-1:0]          coll,
    input  logic [N_SRC*ADDR_W-1:0]   coll_ad,
    output logic                      busy,
    output logic [7:0]                coll_cnt
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - SWEEP_W);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DEPTH-1:0]    entry_q, entry_d;
    logic                summary_q, summary_d;
    logic [7:0]          coll_cnt_q, coll_cnt_d;
    logic [7:0]          rd_q, rd_d;
    logic                sweep_clr;
    logic [15:0]         cnt_sum;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sweep_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_wr_sweep) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                sweep_clr = 1'b1;
                if (cpu_wr_sweep) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(SWEEP_W);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Priority per entry, lowest to highest: sweep clear, source set, CPU clear.
    always_comb begin
        entry_d = entry_q;
        if (sweep_clr) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((j / SWEEP_W) == (int'(ptr_q) / SWEEP_W)) begin
                    entry_d[j] = 1'b0;
                end
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (coll[i]) begin
                entry_d[coll_ad[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (cpu_wr_coll) begin
            entry_d[cpu_ad] = 1'b0;
        end
    end

    always_comb begin
        summary_d = summary_q;
        if (|coll) begin
            summary_d = 1'b1;
        end
        if (cpu_wr_sweep || cpu_wr_collclr) begin
            summary_d = 1'b0;
        end

        cnt_sum = {8'd0, coll_cnt_q};
        for (int i = 0; i < N_SRC; i++) begin
            cnt_sum = cnt_sum + 16'(coll[i]);
        end
        if (cpu_wr_collclr) begin
            coll_cnt_d = 8'd0;
        end else if (cnt_sum > 16'd255) begin
            coll_cnt_d = 8'hFF;
        end else begin
            coll_cnt_d = cnt_sum[7:0];
        end

        rd_d = {summary_q, FILL, entry_q[cpu_ad]};
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            entry_q    <= '0;
            summary_q  <= 1'b0;
            coll_cnt_q <= 8'd0;
            rd_q       <= {1'b0, FILL, 1'b0};
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            entry_q    <= entry_d;
            summary_q  <= summary_d;
            coll_cnt_q <= coll_cnt_d;
            rd_q       <= rd_d;
        end
    end

    assign cpu_rd_coll = rd_q;
    assign busy        = (state_q == SWEEP);
    assign coll_cnt    = coll_cnt_q;

endmodule

// File: tb/tb_collram_gen.sv
// Bench for collram_gen (ADDR_W=6, N_SRC=2, SWEEP_W=16): cycle-level reference
// model compared every negedge, plus directed scenarios with literal expectations.
module tb_collram_gen;

    localparam int ADDR_W  = 6;
    localparam int N_SRC   = 2;
    localparam int SWEEP_W = 16;
    localparam int DEPTH   = 64;
    localparam int CHUNKS  = DEPTH / SWEEP_W;

    logic                    clk = 1'b0;
    logic                    RESET = 1'b0;
    logic [ADDR_W-1:0]       cpu_ad = '0;
    logic                    cpu_wr_coll = 1'b0;
    logic                    cpu_wr_collclr = 1'b0;
    logic                    cpu_wr_sweep = 1'b0;
    logic [7:0]              cpu_rd_coll;
    logic [N_SRC-1:0]        coll = '0;
    logic [N_SRC*ADDR_W-1:0] coll_ad = '0;
    logic                    busy;
    logic [7:0]              coll_cnt;

    collram_gen #(
        .ADDR_W (ADDR_W),
        .N_SRC  (N_SRC),
        .SWEEP_W(SWEEP_W),
        .FILL   (6'b111111)
    ) dut (
        .clk           (clk),
        .RESET         (RESET),
        .cpu_ad        (cpu_ad),
        .cpu_wr_coll   (cpu_wr_coll),
        .cpu_wr_collclr(cpu_wr_collclr),
        .cpu_wr_sweep  (cpu_wr_sweep),
        .cpu_rd_coll   (cpu_rd_coll),
        .coll          (coll),
        .coll_ad       (coll_ad),
        .busy          (busy),
        .coll_cnt      (coll_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    // Reference state: flag array, summary, counter, registered read byte,
    // and sweep age (cycles since sweep start; -1 when no sweep is running).
    bit         m_ent [DEPTH];
    bit         m_sum = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_rd  = 8'h7E;
    int         m_age = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        if (RESET) begin
            foreach (m_ent[k]) m_ent[k] = 1'b0;
            m_sum = 1'b0;
            m_cnt = 0;
            m_rd  = 8'h7E;
            m_age = -1;
        end else begin
            m_rd = {m_sum, 6'b111111, m_ent[cpu_ad]};
            if (m_age >= 0 && m_age < CHUNKS) begin
                for (int k = 0; k < SWEEP_W; k++) m_ent[m_age*SWEEP_W + k] = 1'b0;
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (coll[i]) m_ent[coll_ad[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
            if (cpu_wr_coll) m_ent[cpu_ad] = 1'b0;
            if (coll != '0) m_sum = 1'b1;
            if (cpu_wr_sweep || cpu_wr_collclr) m_sum = 1'b0;
            if (cpu_wr_collclr) m_cnt = 0;
            else begin
                m_cnt = m_cnt + int'(coll[0]) + int'(coll[1]);
                if (m_cnt > 255) m_cnt = 255;
            end
            if (cpu_wr_sweep) m_age = 0;
            else if (m_age >= 0) m_age = (m_age + 1 >= CHUNKS) ? -1 : m_age + 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge RESET);
            model_step();
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("rd_vs_model", int'(cpu_rd_coll), int'(m_rd));
            chk("busy_vs_model", int'(busy), int'(m_age >= 0));
            chk("cnt_vs_model", int'(coll_cnt), m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int nb;

    initial begin
        #1 RESET = 1'b1;
        started = 1'b1;
        #1;
        chk("reset_rd", int'(cpu_rd_coll), 8'h7E);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cnt", int'(coll_cnt), 0);
        tick(); tick();
        RESET = 1'b0;
        cpu_ad = 6'd9;
        tick(); tick();
        chk("reset_read_entry9", int'(cpu_rd_coll), 8'h7E);

        // Two sources hit entry 5 in the same cycle.
        coll = 2'b11;
        coll_ad = {6'd5, 6'd5};
        tick();
        coll = '0;
        cpu_ad = 6'd5;
        tick();
        chk("dual_set_rd", int'(cpu_rd_coll), 8'hFF);
        chk("dual_set_cnt", int'(coll_cnt), 2);

        // CPU clear beats a same-cycle set on the same entry.
        cpu_wr_coll = 1'b1;
        coll = 2'b01;
        coll_ad = {6'd0, 6'd5};
        tick();
        cpu_wr_coll = 1'b0;
        coll = '0;
        tick();
        chk("clr_wins_rd", int'(cpu_rd_coll), 8'hFE);
        chk("clr_wins_cnt", int'(coll_cnt), 3);

        // Fill every entry, then sweep.
        for (int k = 0; k < DEPTH / 2; k++) begin
            coll = 2'b11;
            coll_ad = {6'(2*k + 1), 6'(2*k)};
            tick();
        end
        coll = '0;
        cpu_ad = 6'd37;
        tick();
        chk("filled_rd37", int'(cpu_rd_coll), 8'hFF);
        chk("filled_cnt", int'(coll_cnt), 67);
        cpu_wr_sweep = 1'b1;
        tick();
        cpu_wr_sweep = 1'b0;
        nb = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy) nb++;
            tick();
        end
        chk("sweep_busy_cycles", nb, 4);
        for (int a = 0; a < DEPTH; a++) begin
            cpu_ad = 6'(a);
            tick();
            chk("swept_entry", int'(cpu_rd_coll), 8'h7E);
        end
        chk("sweep_keeps_cnt", int'(coll_cnt), 67);

        // Sets racing the sweep: entry 2 in the chunk being cleared, entry 40 ahead of it.
        cpu_wr_sweep = 1'b1;
        tick();
        cpu_wr_sweep = 1'b0;
        coll = 2'b11;
        coll_ad = {6'd40, 6'd2};
        tick();
        coll = '0;
        tick(); tick(); tick();
        chk("race_sweep_done", int'(busy), 0);
        cpu_ad = 6'd2;
        tick();
        chk("race_entry2_kept", int'(cpu_rd_coll), 8'hFF);
        cpu_ad = 6'd40;
        tick();
        chk("race_entry40_swept", int'(cpu_rd_coll), 8'hFE);

        // Counter saturation.
        cpu_wr_collclr = 1'b1;
        tick();
        cpu_wr_collclr = 1'b0;
        chk("collclr_cnt", int'(coll_cnt), 0);
        coll_ad = '0;
        coll = 2'b01;
        for (int k = 0; k < 254; k++) tick();
        chk("cnt_254", int'(coll_cnt), 254);
        coll = 2'b11;
        tick();
        chk("cnt_sat_255", int'(coll_cnt), 255);
        coll = 2'b01;
        for (int k = 0; k < 50; k++) tick();
        chk("cnt_stays_255", int'(coll_cnt), 255);
        cpu_wr_collclr = 1'b1;
        tick();
        cpu_wr_collclr = 1'b0;
        coll = '0;
        chk("collclr_beats_event", int'(coll_cnt), 0);
        tick();
        chk("collclr_summary", int'(cpu_rd_coll[7]), 0);

        // Reset in the middle of a sweep.
        coll = 2'b11;
        coll_ad = {6'd63, 6'd60};
        tick();
        coll = '0;
        cpu_wr_sweep = 1'b1;
        tick();
        cpu_wr_sweep = 1'b0;
        tick(); tick();
        chk("mid_sweep_busy", int'(busy), 1);
        #1 RESET = 1'b1;
        #1;
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_rd", int'(cpu_rd_coll), 8'h7E);
        chk("async_reset_cnt", int'(coll_cnt), 0);
        tick(); tick();
        RESET = 1'b0;
        nb = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (busy) nb++;
        end
        chk("no_sweep_resume", nb, 0);
        cpu_ad = 6'd60;
        tick();
        chk("reset_cleared_entry60", int'(cpu_rd_coll), 8'h7E);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
